traffic_step_gen: RTL and testbench

//   Timed driver for the 3-phase traffic-light controller (RED->GRN->YEL->RED, z=1 only in YEL).

---
 rtl/traffic_step_gen.sv | 103 ++++++++++
 tb/tb_traffic_step_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_step_gen.sv
// Timed step generator for a RED->GRN->YEL traffic-light controller: turns timebase
// ticks into single-cycle advance pulses, mirrors the controller phase and flags desync.
module traffic_step_gen #(
  parameter int CNT_W         = 8,
  parameter int RED_TICKS     = 20,
  parameter int GRN_TICKS     = 16,
  parameter int GRN_PED_TICKS = 6,
  parameter int YEL_TICKS     = 4
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       enable,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       z_fb,
  output logic       step,
  output logic [1:0] phase,
  output logic       ped_ack,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    PH_RED = 2'b00,
    PH_GRN = 2'b01,
    PH_YEL = 2'b10
  } phase_e;

  localparam logic [CNT_W-1:0] RED_M1     = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GRN_M1     = CNT_W'(GRN_TICKS - 1);
  localparam logic [CNT_W-1:0] GRN_PED_M1 = CNT_W'(GRN_PED_TICKS - 1);
  localparam logic [CNT_W-1:0] YEL_M1     = CNT_W'(YEL_TICKS - 1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dwell_m1;
  logic             step_q, step_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic             adv, count_en;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_RED:  next_phase = PH_GRN;
      PH_GRN:  next_phase = PH_YEL;
      default: next_phase = PH_RED;
    endcase
  endfunction

  always_comb begin
    cnt_d    = cnt_q;
    step_d   = 1'b0;
    phase_d  = phase_q;
    dwell_m1 = RED_M1;
    adv      = step_q & ~err_q;
    count_en = tick & enable & ~err_q & ~step_q;

    case (phase_q)
      PH_GRN:  dwell_m1 = pend_q ? GRN_PED_M1 : GRN_M1;
      PH_YEL:  dwell_m1 = YEL_M1;
      default: dwell_m1 = RED_M1;
    endcase

    // ">=" lets a late pedestrian request cut green short on the very next tick
    if (count_en) begin
      if (cnt_q >= dwell_m1) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (adv) phase_d = next_phase(phase_q);

    ack_d  = adv & (phase_q == PH_YEL) & pend_q;
    pend_d = ped_req | (pend_q & ~ack_d);
    err_d  = err_q | (z_fb != (phase_q == PH_YEL));
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      phase_q <= PH_RED;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign step     = step_q & ~err_q;
  assign phase    = phase_q;
  assign ped_ack  = ack_q;
  assign sync_err = err_q;

endmodule

// File: tb/tb_traffic_step_gen.sv
// Directed bench for traffic_step_gen with RED=3, GRN=4, GRN_PED=2, YEL=2; a small
// controller model driven by step supplies z_fb.
module tb_traffic_step_gen;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       z_force = 1'b0;
  logic       z_fb;
  logic       step;
  logic [1:0] phase;
  logic       ped_ack;
  logic       sync_err;
  logic [1:0] ctrl;
  int         n_checks = 0;
  int         n_fail = 0;

  traffic_step_gen #(
    .CNT_W(8), .RED_TICKS(3), .GRN_TICKS(4), .GRN_PED_TICKS(2), .YEL_TICKS(2)
  ) dut (
    .clk(clk), .areset(areset), .enable(enable), .tick(tick), .ped_req(ped_req),
    .z_fb(z_fb), .step(step), .phase(phase), .ped_ack(ped_ack), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Controller: advances on step, z=1 only in YEL
  always @(posedge clk or posedge areset) begin
    if (areset) ctrl <= 2'd0;
    else if (step) ctrl <= (ctrl == 2'd2) ? 2'd0 : 2'(ctrl + 2'd1);
  end
  assign z_fb = (ctrl == 2'd2) | z_force;

  // One tick pulse, then three idle cycles; reports what followed it
  task automatic pulse_tick(output logic st1, output logic st2, output logic ack2,
                            output logic ack3, output logic [1:0] ph);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0; st1 = step;
    @(negedge clk); st2 = step; ack2 = ped_ack; ph = phase;
    @(negedge clk); ack3 = ped_ack;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", step); end
    n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_checks++; if (ped_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ped_ack); end
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", sync_err); end
    areset = 1'b0;
  endtask

  task automatic test_basic();
    logic s1, s2, a2, a3;
    logic [1:0] ph;
    logic [8:0] exp_st;
    logic [17:0] exp_ph;
    exp_st = 9'b101000100;
    exp_ph = 18'b00_10_10_01_01_01_01_00_00;
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pulse_tick(s1, s2, a2, a3, ph);
      n_checks++; if (s1 !== exp_st[i]) begin n_fail++; $display("FAIL basic_step[%0d]: got %b want %b", i, s1, exp_st[i]); end
      n_checks++; if (s2 !== 1'b0) begin n_fail++; $display("FAIL basic_step_width[%0d]: got %b want 0", i, s2); end
      n_checks++; if (ph !== exp_ph[2*i +: 2]) begin n_fail++; $display("FAIL basic_phase[%0d]: got %0d want %0d", i, ph, exp_ph[2*i +: 2]); end
      n_checks++; if (a2 !== 1'b0) begin n_fail++; $display("FAIL basic_ack[%0d]: got %b want 0", i, a2); end
    end
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", sync_err); end
  endtask

  task automatic test_ped_short();
    logic s1, s2, a2, a3;
    logic [1:0] ph;
    logic [6:0] exp_st, exp_ack;
    logic [13:0] exp_ph;
    exp_st  = 7'b1010100;
    exp_ack = 7'b1000000;
    exp_ph  = 14'b00_10_10_01_01_00_00;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        @(negedge clk); ped_req = 1'b1;
        @(negedge clk); ped_req = 1'b0;
      end
      pulse_tick(s1, s2, a2, a3, ph);
      n_checks++; if (s1 !== exp_st[i]) begin n_fail++; $display("FAIL ped_step[%0d]: got %b want %b", i, s1, exp_st[i]); end
      n_checks++; if (ph !== exp_ph[2*i +: 2]) begin n_fail++; $display("FAIL ped_phase[%0d]: got %0d want %0d", i, ph, exp_ph[2*i +: 2]); end
      n_checks++; if (a2 !== exp_ack[i] || a3 !== 1'b0) begin n_fail++; $display("FAIL ped_ack[%0d]: got %b%b want %b0", i, a2, a3, exp_ack[i]); end
    end
  endtask

  task automatic test_ped_late();
    logic s1, s2, a2, a3;
    logic [1:0] ph;
    logic [14:0] exp_st, exp_ack;
    logic [29:0] exp_ph;
    exp_st  = 15'b101010010100100;
    exp_ack = 15'b100000010000000;
    exp_ph  = 30'b00_10_10_01_01_00_00_00_10_10_01_01_01_00_00;
    for (int i = 0; i < 15; i++) begin
      if (i == 5) ped_req = 1'b1;
      pulse_tick(s1, s2, a2, a3, ph);
      if (i == 7) ped_req = 1'b0;
      n_checks++; if (s1 !== exp_st[i]) begin n_fail++; $display("FAIL late_step[%0d]: got %b want %b", i, s1, exp_st[i]); end
      n_checks++; if (ph !== exp_ph[2*i +: 2]) begin n_fail++; $display("FAIL late_phase[%0d]: got %0d want %0d", i, ph, exp_ph[2*i +: 2]); end
      n_checks++; if (a2 !== exp_ack[i] || a3 !== 1'b0) begin n_fail++; $display("FAIL late_ack[%0d]: got %b%b want %b0", i, a2, a3, exp_ack[i]); end
    end
  endtask

  task automatic test_enable();
    logic s1, s2, a2, a3;
    logic [1:0] ph;
    logic [7:0] exp_st;
    logic [15:0] exp_ph;
    exp_st = 8'b10100010;
    exp_ph = 16'b00_10_10_01_01_01_01_00;
    pulse_tick(s1, s2, a2, a3, ph);
    n_checks++; if (s1 !== 1'b0 || ph !== 2'd0) begin n_fail++; $display("FAIL en_pre: got step %b phase %0d want 0 0", s1, ph); end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pulse_tick(s1, s2, a2, a3, ph);
      n_checks++; if (s1 !== 1'b0 || ph !== 2'd0) begin n_fail++; $display("FAIL en_hold[%0d]: got step %b phase %0d want 0 0", i, s1, ph); end
    end
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse_tick(s1, s2, a2, a3, ph);
      n_checks++; if (s1 !== exp_st[i]) begin n_fail++; $display("FAIL en_step[%0d]: got %b want %b", i, s1, exp_st[i]); end
      n_checks++; if (ph !== exp_ph[2*i +: 2]) begin n_fail++; $display("FAIL en_phase[%0d]: got %0d want %0d", i, ph, exp_ph[2*i +: 2]); end
    end
  endtask

  task automatic test_sync_err();
    logic s1, s2, a2, a3;
    logic [1:0] ph;
    @(negedge clk); z_force = 1'b1;
    @(negedge clk);
    n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", sync_err); end
    for (int i = 0; i < 4; i++) begin
      pulse_tick(s1, s2, a2, a3, ph);
      n_checks++; if (s1 !== 1'b0 || ph !== 2'd0) begin n_fail++; $display("FAIL err_hold[%0d]: got step %b phase %0d want 0 0", i, s1, ph); end
    end
    n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", sync_err); end
    @(negedge clk); areset = 1'b1; z_force = 1'b0;
    #1;
    n_checks++; if ({step, ped_ack, sync_err} !== 3'b000 || phase !== 2'd0) begin n_fail++; $display("FAIL err_reset: got step/ack/err %b%b%b phase %0d want 000 0", step, ped_ack, sync_err, phase); end
    @(negedge clk); areset = 1'b0;
  endtask

  task automatic test_reset_in_step();
    logic s1, s2, a2, a3;
    logic [1:0] ph;
    pulse_tick(s1, s2, a2, a3, ph);
    pulse_tick(s1, s2, a2, a3, ph);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL rst_step_pre: got %b want 1", step); end
    areset = 1'b1;
    #1;
    n_checks++; if (step !== 1'b0 || phase !== 2'd0) begin n_fail++; $display("FAIL rst_async: got step %b phase %0d want 0 0", step, phase); end
    @(negedge clk); @(negedge clk); areset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (step !== 1'b0 || phase !== 2'd0 || sync_err !== 1'b0) begin n_fail++; $display("FAIL rst_after: got step %b phase %0d err %b want 0 0 0", step, phase, sync_err); end
    for (int i = 0; i < 3; i++) begin
      pulse_tick(s1, s2, a2, a3, ph);
      n_checks++; if (s1 !== (i == 2)) begin n_fail++; $display("FAIL rst_restart[%0d]: got %b want %b", i, s1, (i == 2)); end
    end
    n_checks++; if (phase !== 2'd1) begin n_fail++; $display("FAIL rst_restart_phase: got %0d want 1", phase); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ped_short();
    test_ped_late();
    test_enable();
    test_sync_err();
    test_reset_in_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
